// File: rtl/button_event_decoder_pkg.sv
// Shared types and constants for the button event decoder: state encoding,
// default timing for the 25 MHz board clock and the counter-width helper.
package button_event_decoder_pkg;

    typedef enum logic [2:0] {
        StArm    = 3'd0,
        StIdle   = 3'd1,
        StPress1 = 3'd2,
        StGap    = 3'd3,
        StPress2 = 3'd4,
        StLong   = 3'd5
    } state_e;

    localparam int unsigned LongCountDefault = 12_500_000;  // 0.5 s @ 25 MHz
    localparam int unsigned DoubleGapDefault = 7_500_000;   // 0.3 s @ 25 MHz

    function automatic int unsigned cnt_width(input int unsigned long_count,
                                              input int unsigned double_gap);
        int unsigned top;
        top = (long_count > double_gap) ? long_count : double_gap;
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/button_event_decoder_if.sv
// Button level in, event pulses out. The decoder uses the slave modport; the
// driver of the debounced level and consumer of the events uses master.
interface button_event_decoder_if;

    logic i_BTN;
    logic o_PRESS;
    logic o_RELEASE;
    logic o_SHORT;
    logic o_LONG;
    logic o_DOUBLE;
    logic o_HELD;

    modport master (
        output i_BTN,
        input  o_PRESS, o_RELEASE, o_SHORT, o_LONG, o_DOUBLE, o_HELD
    );

    modport slave (
        input  i_BTN,
        output o_PRESS, o_RELEASE, o_SHORT, o_LONG, o_DOUBLE, o_HELD
    );

endinterface

// File: rtl/button_event_decoder.sv
// Turns a debounced button level into one-cycle press/release/short/long/double
// pulses plus a held level. Input register, counter and FSM are all inline.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int unsigned LONG_COUNT = LongCountDefault,
    parameter int unsigned DOUBLE_GAP = DoubleGapDefault
) (
    input logic                   CLK,
    input logic                   i_RST_N,
    button_event_decoder_if.slave bus
);

    localparam int unsigned     CntW     = cnt_width(LONG_COUNT, DOUBLE_GAP);
    localparam logic [CntW-1:0] LongLast = CntW'(LONG_COUNT - 1);
    localparam logic [CntW-1:0] GapLast  = CntW'(DOUBLE_GAP - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            r_btn_q;
    logic            btn_vld_q;
    logic            press_q, press_d;
    logic            release_q, release_d;
    logic            short_q, short_d;
    logic            long_q, long_d;
    logic            double_q, double_d;
    logic            held_q, held_d;

    always_comb begin
        state_d   = state_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        double_d  = 1'b0;

        case (state_q)
            // r_btn_q is only meaningful once it has sampled i_BTN after reset,
            // so a button held through reset cannot be mistaken for a release.
            StArm: begin
                if (btn_vld_q && !r_btn_q) state_d = StIdle;
            end
            StIdle: begin
                if (r_btn_q) begin
                    state_d = StPress1;
                    press_d = 1'b1;
                end
            end
            StPress1: begin
                if (!r_btn_q) begin
                    state_d   = StGap;
                    release_d = 1'b1;
                end else if (cnt_q == LongLast) begin
                    state_d = StLong;
                    long_d  = 1'b1;
                end
            end
            StGap: begin
                if (r_btn_q) begin
                    state_d  = StPress2;
                    press_d  = 1'b1;
                    double_d = 1'b1;
                end else if (cnt_q == GapLast) begin
                    state_d = StIdle;
                    short_d = 1'b1;
                end
            end
            StPress2, StLong: begin
                if (!r_btn_q) begin
                    state_d   = StIdle;
                    release_d = 1'b1;
                end
            end
            default: state_d = StArm;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == StPress1 || state_q == StGap) begin
            cnt_d = cnt_q + CntW'(1);
        end else begin
            cnt_d = cnt_q;
        end

        held_d = (state_d == StPress1) || (state_d == StPress2) || (state_d == StLong);
    end

    always_ff @(posedge CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_q   <= StArm;
            cnt_q     <= '0;
            r_btn_q   <= 1'b0;
            btn_vld_q <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            double_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            r_btn_q   <= bus.i_BTN;
            btn_vld_q <= 1'b1;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            double_q  <= double_d;
            held_q    <= held_d;
        end
    end

    assign bus.o_PRESS   = press_q;
    assign bus.o_RELEASE = release_q;
    assign bus.o_SHORT   = short_q;
    assign bus.o_LONG    = long_q;
    assign bus.o_DOUBLE  = double_q;
    assign bus.o_HELD    = held_q;

endmodule
